// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring shift-subtract integer divider.
//
// Signed operands are divided as magnitudes and the results are negated at the end,
// so the quotient truncates toward zero and the remainder takes the dividend's sign.
// A zero divisor skips the iteration and returns all-ones / original dividend.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      request, sampled only while idle
//   signed_i     1 = two's complement division, 0 = unsigned (captured with start_i)
//   dividend_i   dividend (captured with start_i)
//   divisor_i    divisor (captured with start_i)
//   busy_o       operation in progress
//   done_o       one-cycle pulse, results valid from this cycle on
//   quotient_o   registered quotient
//   remainder_o  registered remainder
//   div_zero_o   last completed operation had a zero divisor
module seq_divider #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  div_zero_o
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [5:0] LastCnt = 6'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e         state_q;
  logic [5:0]     cnt_q;
  logic [W-1:0]   rem_q;     // partial remainder
  logic [W-1:0]   quo_q;     // dividend shifts out the top, quotient bits shift in
  logic [W-1:0]   dvs_q;     // divisor magnitude
  logic           signed_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic           zero_q;

  logic [W-1:0]   dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic           q_neg;
  logic           r_neg;
  logic [W:0]     trial;
  logic           take;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  always_comb begin
    dvd_abs = (signed_i && dividend_i[W-1]) ? -dividend_i : dividend_i;
    dvs_abs = (signed_i && divisor_i[W-1])  ? -divisor_i  : divisor_i;
    q_neg   = signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
    r_neg   = signed_i & dividend_i[W-1];

    // The shifted remainder is W+1 bits wide. When its top bit (rem_q[W-1]) is set it
    // already exceeds any divisor, so the subtract is taken; otherwise the W+1-bit
    // trial difference's sign bit decides. Either way the low W bits are the result.
    trial    = {1'b0, rem_q[W-2:0], quo_q[W-1]} - {1'b0, dvs_q};
    take     = rem_q[W-1] | ~trial[W];
    rem_next = take ? trial[W-1:0] : {rem_q[W-2:0], quo_q[W-1]};
    quo_next = {quo_q[W-2:0], take};

    q_fix = (signed_q && q_neg_q) ? -quo_q : quo_q;
    r_fix = (signed_q && r_neg_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      signed_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_o   <= 1'b1;
            signed_q <= signed_i;
            cnt_q    <= '0;
            if (divisor_i == '0) begin
              // Preload the fixed divide-by-zero answer; FIX passes it through unchanged.
              zero_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend_i;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              state_q <= StFix;
            end else begin
              zero_q  <= 1'b0;
              quo_q   <= dvd_abs;
              dvs_q   <= dvs_abs;
              rem_q   <= '0;
              q_neg_q <= q_neg;
              r_neg_q <= r_neg;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient_o  <= q_fix;
          remainder_o <= r_fix;
          div_zero_o  <= zero_q;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a start in the current (negedge) cycle; returns at the negedge after the
  // accepting edge, with operands scrambled to prove they were captured.
  task automatic push_start(input logic s, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eq, input logic [31:0] er, input logic ez,
                            input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.z = ez; e.lat = 8'(lat);
    sb.push_back(e);
    signed_i = s; dividend_i = x; divisor_i = y; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    dividend_i = $urandom;
    divisor_i = $urandom;
  endtask

  // Wait for done_o, optionally pulsing a spurious start at cycle 'inject', then
  // pop the scoreboard and compare. Leaves the bench in the done_o cycle.
  task automatic wait_result(input int inject);
    int   cyc;
    int   busy_cnt;
    exp_t e;
    cyc = 0;
    busy_cnt = 0;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (busy_o === 1'b1) busy_cnt++;
      check("hold_q", {32'd0, quotient_o}, {32'd0, last_q});
      if (inject != 0 && cyc == inject) begin
        signed_i = 1'b0; dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(cyc), 64'(e.lat));
      check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
      check("busy_at_done", {63'd0, busy_o}, 64'd0);
      check("quotient", {32'd0, quotient_o}, {32'd0, e.q});
      check("remainder", {32'd0, remainder_o}, {32'd0, e.r});
      check("div_zero", {63'd0, div_zero_o}, {63'd0, e.z});
      last_q = e.q;
    end
  endtask

  task automatic done_low;
    @(negedge clk);
    check("done_pulse_width", {63'd0, done_o}, 64'd0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_done"}, {63'd0, done_o}, 64'd0);
    check({tag, "_q"}, {32'd0, quotient_o}, 64'd0);
    check({tag, "_r"}, {32'd0, remainder_o}, 64'd0);
    check({tag, "_z"}, {63'd0, div_zero_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, mq, mr;
    logic        rs;
    int          pulses;
    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (2) @(negedge clk);
    reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Unsigned 100 / 7
    push_start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    wait_result(0);
    done_low();

    // Signed mixed signs
    push_start(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    wait_result(0);
    done_low();
    push_start(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    wait_result(0);
    done_low();

    // Unsigned large operand
    push_start(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
    wait_result(0);
    done_low();

    // Divide by zero, then a valid divide clears the flag
    push_start(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    wait_result(0);
    done_low();
    push_start(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 33);
    wait_result(0);
    done_low();

    // Signed overflow
    push_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    wait_result(0);
    done_low();

    // Start while busy is ignored; then a start in the done cycle is accepted
    push_start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    wait_result(10);
    push_start(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);
    wait_result(0);
    done_low();

    // Operand sweep against the language's own division operators
    for (int i = 0; i < 8; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom >> (i * 3);
      if (rb == 32'd0) rb = 32'd3;
      if (rs && rb == 32'hFFFF_FFFF) rb = 32'd5;
      if (rs) begin
        mq = $signed(ra) / $signed(rb);
        mr = $signed(ra) % $signed(rb);
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      push_start(rs, ra, rb, mq, mr, 1'b0, 33);
      wait_result(0);
      done_low();
    end

    // Reset in the middle of an operation
    push_start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    repeat (14) @(negedge clk);
    rst_i = 1'b1;
    #1;
    reset_outputs("midreset");
    void'(sb.pop_back());
    last_q = '0;
    @(negedge clk);
    rst_i = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) pulses++;
    end
    check("no_done_after_abort", 64'(pulses), 64'd0);
    push_start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    wait_result(0);
    done_low();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit integer divider for the pipeline CPU's execute stage. It supports signed and unsigned division and handles divide-by-zero and signed overflow.

- The combinational ALU multiplies in one cycle; division instead runs through this restoring shift-subtract unit.
- Operands are captured on a start handshake, and results are held until the next operation.
- Hazard logic stalls the pipeline while `busy_o` is high.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand and result width. The iteration count equals `DATA_WIDTH`.

Ports:
- `clk_i` input 1: single clock; all state changes on its rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `start_i` input 1: request. Sampled only when the unit is idle.
- `signed_i` input 1: 1 = signed (two's complement) division, 0 = unsigned. Captured with `start_i`.
- `dividend_i` input `DATA_WIDTH`: dividend, captured with `start_i`.
- `divisor_i` input `DATA_WIDTH`: divisor, captured with `start_i`.
- `busy_o` output 1: an operation is in progress.
- `done_o` output 1: one-cycle pulse; results valid from this cycle on.
- `quotient_o` output `DATA_WIDTH`: registered quotient.
- `remainder_o` output `DATA_WIDTH`: registered remainder.
- `div_zero_o` output 1: the last completed operation had divisor == 0. Registered and updated together with the results.

## Operation

States:
- IDLE
- RUN, with a 6-bit iteration counter
- FIX

Transitions and behaviour:
- **IDLE, start_i = 1, divisor ≠ 0:**
  - Latch `signed_i`.
  - Latch operand magnitudes: absolute value when signed and the MSB is 1, raw value otherwise.
  - Latch sign flags: quotient sign = dividend MSB XOR divisor MSB; remainder sign = dividend MSB. Both are forced to 0 when unsigned.
  - Clear the partial remainder and counter, then go to RUN.
- **IDLE, start_i = 1, divisor = 0:** go directly to FIX with the zero flag set. RUN is skipped.
- **RUN:** each cycle performs one restoring step.
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude using a (`DATA_WIDTH`+1)-bit subtractor.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After `DATA_WIDTH` steps, go to FIX.
- **FIX:**
  - Negate the quotient and/or remainder according to the sign flags.
  - Load `quotient_o`, `remainder_o` and `div_zero_o`, then go to IDLE.
  - `done_o` is registered high for the following cycle.
- **Divide by zero:** `quotient_o` = all ones and `remainder_o` = the original dividend, for both signed and unsigned.
- **Signed overflow** (most-negative / −1): the natural algorithm yields quotient = 0x80000000 and remainder = 0. No special casing is needed; the bench checks it.
- **Remainder sign:** follows the dividend; the quotient truncates toward zero.
- **Inputs while busy:** `start_i` and operand changes are ignored and have no effect on the running operation.

## Timing

- **Reset** (async, immediate):
  - state = IDLE
  - `busy_o` = 0, `done_o` = 0, `div_zero_o` = 0
  - `quotient_o` = 0, `remainder_o` = 0
  - internal registers = 0
- **Reset mid-operation:** aborts the operation; there is no `done_o` pulse. The first start after reset release proceeds normally.
- **Latency, normal divide:** start accepted at edge N.
  - `busy_o` = 1 from edge N through edge N+`DATA_WIDTH`+1.
  - RUN covers edges N+1 … N+32.
  - FIX is at edge N+33; `busy_o` falls and `done_o` rises at that edge, giving 33 cycles at the default width.
- **Latency, divide by zero:** start at edge N, FIX at edge N+1, `done_o` after edge N+1 (1 cycle).
- **`done_o`:** high for exactly one cycle per accepted start.
- **Outputs:** `quotient_o`, `remainder_o` and `div_zero_o` change only at the FIX edge and hold until the next FIX.
- **Back-to-back:** the unit is IDLE during the `done_o` cycle, so a start in that cycle is accepted. There is zero dead time between operations.

## Test plan

- **Unsigned divide:** unsigned 100 / 7 → `quotient_o` = 14, `remainder_o` = 2, `div_zero_o` = 0. `done_o` pulses exactly 33 cycles after the start edge; `busy_o` is high for 33 cycles.
- **Signed, mixed signs:**
  - −7 / 2 → `quotient_o` = 0xFFFFFFFD, `remainder_o` = 0xFFFFFFFF.
  - 7 / −2 → `quotient_o` = 0xFFFFFFFD, `remainder_o` = 1.
- **Unsigned, large operand:** 0xFFFFFFFF / 0x10 → `quotient_o` = 0x0FFFFFFF, `remainder_o` = 0xF.
- **Divide by zero:** signed 5 / 0 → `done_o` 1 cycle after start, `quotient_o` = 0xFFFFFFFF, `remainder_o` = 5, `div_zero_o` = 1. The next valid divide clears `div_zero_o`.
- **Signed overflow:** signed 0x80000000 / 0xFFFFFFFF → `quotient_o` = 0x80000000, `remainder_o` = 0, `div_zero_o` = 0.
- **Start during busy, then back-to-back:**
  - Pulse `start_i` with 9 / 3 at cycle 10 of an operation → ignored; the first result is unaffected.
  - A start asserted in the `done_o` cycle is accepted, and its `done_o` pulses 33 cycles later.
- **Reset mid-operation:** assert `rst_i` at cycle 15 of an operation → all outputs 0 immediately and no `done_o` pulse. A fresh 100 / 7 after reset release completes correctly.
